fir_ntap_mac: RTL and testbench

//  Parametrised N-tap direct-form FIR (successor of the fixed 3-tap filter), time-multiplexed on one MAC.

---
 rtl/fir_pkg.sv | 44 ++++
 rtl/fir_mac_unit.sv | 48 ++++
 rtl/fir_ntap_mac.sv | 158 +++++++++++++++
 tb/tb_fir_ntap_mac.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and elaboration-time helpers for the N-tap time-multiplexed FIR.
package fir_pkg;

    // Controller states: wait for a sample, run the taps, present the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } fir_state_e;

    // Accumulator width: a full-precision product plus enough guard bits
    // for NTAPS additions, so the sum can never overflow.
    function automatic int unsigned acc_w(input int unsigned wl,
                                          input int unsigned cwl,
                                          input int unsigned ntaps);
        return wl + cwl + $clog2(ntaps);
    endfunction

    // Width of a tap index / delay-line pointer.
    function automatic int unsigned ptr_w(input int unsigned ntaps);
        return (ntaps > 1) ? $clog2(ntaps) : 1;
    endfunction

    // Width of the tap counter, which must also hold NTAPS itself (drain step).
    function automatic int unsigned cnt_w(input int unsigned ntaps);
        return $clog2(ntaps + 1);
    endfunction

    // Clamp a signed value to the range of a signed owl-bit word.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int unsigned       owl);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (owl - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (owl - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Registered signed multiply-accumulate: the product is registered first,
// then added into the accumulator one cycle later.
module fir_mac_unit #(
    parameter int unsigned AW   = 16,
    parameter int unsigned BW   = 16,
    parameter int unsigned ACCW = 35
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clr_i,
    input  logic                   en_i,
    input  logic signed [AW-1:0]   a_i,
    input  logic signed [BW-1:0]   b_i,
    output logic signed [ACCW-1:0] acc_o
);

    logic signed [AW+BW-1:0] prod_q, prod_d;
    logic                    pvld_q, pvld_d;
    logic signed [ACCW-1:0]  acc_q, acc_d;

    // Next-state: product stage tracks en_i, accumulator adds the registered product.
    always_comb begin
        prod_d = a_i * b_i;
        pvld_d = en_i & ~clr_i;
        acc_d  = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (pvld_q) begin
            acc_d = acc_q + ACCW'(prod_q);
        end
    end

    // Pipeline and accumulator registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prod_q <= '0;
            pvld_q <= 1'b0;
            acc_q  <= '0;
        end else begin
            prod_q <= prod_d;
            pvld_q <= pvld_d;
            acc_q  <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/fir_ntap_mac.sv
// N-tap direct-form FIR sharing one MAC across all taps, with run-time
// loadable coefficients and valid/ready handshakes on both sides.
// Build option: FIR_SAT_EN selects round-half-up plus saturation on the output;
// without it the output is the truncated, wrapping slice of the shifted accumulator.
module fir_ntap_mac
    import fir_pkg::*;
#(
    parameter int unsigned WL    = 16,
    parameter int unsigned CWL   = 16,
    parameter int unsigned NTAPS = 8,
    parameter int unsigned OWL   = 16,
    parameter int unsigned SHIFT = 15
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         x_valid,
    output logic                         x_ready,
    input  logic signed [WL-1:0]         x,
    input  logic                         coef_we,
    input  logic [ptr_w(NTAPS)-1:0]      coef_addr,
    input  logic signed [CWL-1:0]        coef_data,
    output logic                         y_valid,
    input  logic                         y_ready,
    output logic signed [OWL-1:0]        y
);

    localparam int unsigned ACCW = acc_w(WL, CWL, NTAPS);
    localparam int unsigned PW   = ptr_w(NTAPS);
    localparam int unsigned KW   = cnt_w(NTAPS);

    fir_state_e             state_q, state_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [KW-1:0]          k_q, k_d;
    logic signed [WL-1:0]   dline_q [NTAPS];
    logic signed [CWL-1:0]  coef_q  [NTAPS];

    logic                   mac_clr, mac_en;
    logic [PW-1:0]          rd_idx, c_idx;
    int unsigned            rd_sum;
    logic signed [ACCW-1:0] acc;

    // Controller: next state, counters and handshake outputs.
    // The MAC unit registers its product, so MAC lingers one extra cycle
    // (k == NTAPS) to let the last product land in the accumulator.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        wr_ptr_d = wr_ptr_q;
        x_ready  = 1'b0;
        y_valid  = 1'b0;
        mac_clr  = 1'b0;
        mac_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                x_ready = ~RST;
                if (x_valid) begin
                    state_d = MAC;
                    k_d     = '0;
                    mac_clr = 1'b1;
                end
            end
            MAC: begin
                if (k_q == KW'(NTAPS)) begin
                    state_d = OUT;
                end else begin
                    mac_en = 1'b1;
                    k_d    = k_q + 1'b1;
                end
            end
            OUT: begin
                y_valid = 1'b1;
                if (y_ready) begin
                    state_d  = IDLE;
                    wr_ptr_d = (wr_ptr_q == PW'(NTAPS - 1)) ? '0 : wr_ptr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            k_q      <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Tap addressing: x[n-k] sits at (wr_ptr - k) mod NTAPS, h[k] at k.
    always_comb begin
        rd_sum = NTAPS + 32'(wr_ptr_q) - 32'(k_q);
        if (rd_sum >= NTAPS) begin
            rd_sum = rd_sum - NTAPS;
        end
        rd_idx = PW'(rd_sum);
        c_idx  = (32'(k_q) < NTAPS) ? PW'(k_q) : '0;
    end

    // Delay line and coefficient file; both only change while IDLE, and a
    // coefficient write in the same cycle as an accepted sample is seen by it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < NTAPS; i++) begin
                dline_q[i] <= '0;
                coef_q[i]  <= '0;
            end
        end else begin
            if ((state_q == IDLE) && coef_we && (32'(coef_addr) < NTAPS)) begin
                coef_q[coef_addr] <= coef_data;
            end
            if ((state_q == IDLE) && x_valid) begin
                dline_q[wr_ptr_q] <= x;
            end
        end
    end

    fir_mac_unit #(
        .AW   (CWL),
        .BW   (WL),
        .ACCW (ACCW)
    ) u_mac (
        .clk_i (CLK),
        .rst_i (RST),
        .clr_i (mac_clr),
        .en_i  (mac_en),
        .a_i   (coef_q[c_idx]),
        .b_i   (dline_q[rd_idx]),
        .acc_o (acc)
    );

`ifdef FIR_SAT_EN
    localparam int unsigned          RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [ACCW:0] RND = (SHIFT > 0) ? ((ACCW+1)'(1) <<< RSH) : '0;

    logic signed [ACCW:0] rnd_sum;
    logic signed [ACCW:0] shifted;
    logic signed [63:0]   wide;

    // Output scaling: round half up, arithmetic shift, clamp to OWL bits.
    always_comb begin
        rnd_sum = {acc[ACCW-1], acc} + RND;
        shifted = rnd_sum >>> SHIFT;
        wide    = {{(63 - ACCW){shifted[ACCW]}}, shifted};
        y       = OWL'(saturate(wide, OWL));
    end
`else
    // Output scaling: arithmetic shift, keep the low OWL bits (wraps on overflow).
    always_comb begin
        y = OWL'(acc >>> SHIFT);
    end
`endif

endmodule

// File: tb/tb_fir_ntap_mac.sv
// Self-checking bench for fir_ntap_mac: two instances share all inputs
// (different output scaling) and are compared against a convolution model.
module tb_fir_ntap_mac;

    localparam int NT = 3;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              x_valid = 1'b0;
    logic signed [15:0] x = '0;
    logic              coef_we = 1'b0;
    logic [1:0]        coef_addr = '0;
    logic signed [15:0] coef_data = '0;
    logic              y_ready = 1'b1;

    logic              x_ready, y_valid, x_ready_b, y_valid_b;
    logic signed [15:0] ya;
    logic signed [11:0] yb;

    always #5 CLK = ~CLK;

    fir_ntap_mac #(.WL(16), .CWL(16), .NTAPS(NT), .OWL(16), .SHIFT(0)) dut_a (
        .CLK(CLK), .RST(RST), .x_valid(x_valid), .x_ready(x_ready), .x(x),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .y_valid(y_valid), .y_ready(y_ready), .y(ya)
    );

    fir_ntap_mac #(.WL(16), .CWL(16), .NTAPS(NT), .OWL(12), .SHIFT(4)) dut_b (
        .CLK(CLK), .RST(RST), .x_valid(x_valid), .x_ready(x_ready_b), .x(x),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .y_valid(y_valid_b), .y_ready(y_ready), .y(yb)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    longint hist[$];       // newest sample at index 0
    longint h[NT];
    int     exp_acc = 0;   // samples the bench expects accepted
    int     exp_out = 0;   // results the bench expects delivered
    int     acc_cnt = 0;
    int     out_cnt = 0;

    function automatic longint conv();
        longint s = 0;
        for (int k = 0; k < NT; k++) begin
            if (k < hist.size()) s += h[k] * hist[k];
        end
        return s;
    endfunction

    function automatic longint scale(input longint a, input int sh, input int owl);
        longint v;
        longint one = 1;
`ifdef FIR_SAT_EN
        v = a;
        if (sh > 0) v += (one << (sh - 1));
        v = v >>> sh;
        if (v > (one << (owl - 1)) - 1) v = (one << (owl - 1)) - 1;
        if (v < -(one << (owl - 1)))    v = -(one << (owl - 1));
`else
        v = a >>> sh;
        v = v & ((one << owl) - 1);
        if (v >= (one << (owl - 1))) v -= (one << owl);
`endif
        return v;
    endfunction

    function automatic void model_reset();
        hist.delete();
        for (int k = 0; k < NT; k++) h[k] = 0;
    endfunction

    // handshake counters
    always @(posedge CLK) begin
        if (!RST) begin
            if (x_valid && x_ready) acc_cnt++;
            if (y_valid && y_ready) out_cnt++;
        end
    end

    // ---------------- stimulus tasks (entered and left at a negedge) ----------------
    task automatic wait_idle();
        int n = 0;
        while (!x_ready && n < 60) begin
            @(negedge CLK);
            n++;
        end
        chk("x_ready_idle", x_ready, 1);
    endtask

    task automatic load_coef(input int addr, input longint val);
        wait_idle();
        coef_we = 1'b1; coef_addr = 2'(addr); coef_data = 16'(val);
        h[addr] = val;
        @(negedge CLK);
        coef_we = 1'b0;
    endtask

    // One sample through the filter. we: coefficient write alongside the accept.
    // mac_we: hold a write of h[0]=7 through MAC/OUT (must be dropped).
    // bp: hold y_ready low for 10 cycles once the result appears.
    task automatic send(input longint xv, input bit we, input int addr, input longint cd,
                        input bit mac_we, input bit bp, output longint e);
        int lat;
        longint yhold;
        wait_idle();
        x_valid = 1'b1; x = 16'(xv);
        if (we) begin
            coef_we = 1'b1; coef_addr = 2'(addr); coef_data = 16'(cd);
            h[addr] = cd;
        end
        if (bp) y_ready = 1'b0;
        @(posedge CLK);
        hist.push_front(longint'(x));
        if (hist.size() > NT) void'(hist.pop_back());
        e = conv();
        exp_acc++;
        exp_out++;
        @(negedge CLK);
        x_valid = 1'b0;
        coef_we = mac_we;
        if (mac_we) begin
            coef_addr = 2'd0; coef_data = 16'sd7;
        end
        lat = 0;
        while (!y_valid && lat < 60) begin
            @(negedge CLK);
            lat++;
        end
        chk("latency", lat, NT + 1);
        chk("x_ready_busy", x_ready, 0);
        chk("yA", longint'(ya), scale(e, 0, 16));
        chk("yB", longint'(yb), scale(e, 4, 12));
        chk("y_valid_B", y_valid_b, 1);
        if (bp) begin
            yhold = longint'(ya);
            for (int i = 0; i < 10; i++) begin
                x_valid = 1'b1; x = 16'($urandom);
                @(negedge CLK);
                chk("bp_y_stable", longint'(ya), yhold);
                chk("bp_y_valid", y_valid, 1);
                chk("bp_x_ready", x_ready, 0);
            end
            x_valid = 1'b0;
            y_ready = 1'b1;
        end
        @(negedge CLK);
        coef_we = 1'b0;
        chk("y_valid_drop", y_valid, 0);
    endtask

    // ---------------- main sequence ----------------
    longint e;
    longint imp_x[4] = '{1, 0, 0, 0};
    longint imp_y[4] = '{3, -3, 5, 0};

    initial begin
        model_reset();
        repeat (3) @(negedge CLK);
        chk("rst_x_ready", x_ready, 0);
        chk("rst_y_valid", y_valid, 0);
        chk("rst_y", longint'(ya), 0);
        RST = 1'b0;
        @(negedge CLK);

        // impulse response
        load_coef(0, 3); load_coef(1, -3); load_coef(2, 5);
        for (int i = 0; i < 4; i++) begin
            send(imp_x[i], 0, 0, 0, 0, 0, e);
            chk("impulse", longint'(ya), imp_y[i]);
        end

        // saturation / wrap on a full-scale input
        for (int k = 0; k < NT; k++) load_coef(k, 32767);
        for (int i = 0; i < NT; i++) send(32767, 0, 0, 0, 0, 0, e);
`ifdef FIR_SAT_EN
        chk("sat_full", longint'(ya), 32767);
`else
        chk("wrap_full", longint'(ya), 3);
`endif

        // random coefficients, 2*NT+1 samples across the pointer wrap
        for (int k = 0; k < NT; k++) load_coef(k, longint'(16'($urandom)));
        for (int i = 0; i < 2 * NT + 1; i++) send(longint'(16'($urandom)), 0, 0, 0, 0, 0, e);

        // coefficient write during MAC is dropped, in IDLE with accept it applies
        send(longint'(16'($urandom)), 0, 0, 0, 1, 0, e);
        send(longint'(16'($urandom)), 0, 0, 0, 0, 0, e);
        send(longint'(16'($urandom)), 1, 0, 7, 0, 0, e);

        // backpressure
        send(longint'(16'($urandom)), 0, 0, 0, 0, 1, e);

        // mixed random traffic
        for (int i = 0; i < 20; i++) begin
            send(longint'(16'($urandom)), ($urandom_range(0, 3) == 0), $urandom_range(0, NT - 1),
                 longint'(16'($urandom)), ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0), e);
        end

        // reset in the middle of a computation
        wait_idle();
        x_valid = 1'b1; x = 16'sd1234;
        @(negedge CLK);
        x_valid = 1'b0;
        exp_acc++;
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("midrst_x_ready", x_ready, 0);
        chk("midrst_y_valid", y_valid, 0);
        chk("midrst_y", longint'(ya), 0);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        @(negedge CLK);
        chk("post_rst_x_ready", x_ready, 1);
        chk("post_rst_y_valid", y_valid, 0);
        chk("post_rst_y", longint'(ya), 0);
        load_coef(0, 100); load_coef(1, 200); load_coef(2, 300);
        send(5, 0, 0, 0, 0, 0, e);
        chk("zero_history", longint'(ya), 500);
        send(-2, 0, 0, 0, 0, 0, e);

        repeat (3) @(negedge CLK);
        chk("accept_count", acc_cnt, exp_acc);
        chk("output_count", out_cnt, exp_out);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
